// File: rtl/csr_exc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_exc_pkg (package)
//  Description : Shared constants for the exception/interrupt/ERTN commit
//                sequencer: ecode/esubcode values, ws_exc cause-bit indices
//                and the sequencer state encoding.
//  Optional    : none (the CSR_EXC_COUNT_EN macro is used by csr_exc_ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_exc_pkg;

  // Bit positions inside the ws_exc cause vector
  localparam int c_EXC_ADEF = 0;
  localparam int c_EXC_INE  = 1;
  localparam int c_EXC_SYS  = 2;
  localparam int c_EXC_BRK  = 3;
  localparam int c_EXC_ALE  = 4;

  // Exception codes presented to the CSR file (ESTAT.Ecode)
  localparam logic [5:0] c_ECODE_INT  = 6'h00;
  localparam logic [5:0] c_ECODE_ADEF = 6'h08;
  localparam logic [5:0] c_ECODE_ALE  = 6'h09;
  localparam logic [5:0] c_ECODE_SYS  = 6'h0B;
  localparam logic [5:0] c_ECODE_BRK  = 6'h0C;
  localparam logic [5:0] c_ECODE_INE  = 6'h0D;

  // Exception sub-codes (ESTAT.EsubCode)
  localparam logic [8:0] c_ESUB_ADEF = 9'h000;
  localparam logic [8:0] c_ESUB_NONE = 9'h000;

  // Sequencer state encoding
  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_COMMIT   = 2'd1;
  localparam logic [1:0] c_ST_REDIRECT = 2'd2;

endpackage : csr_exc_pkg
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : exc_prio_enc
//  Description : Combinational priority encoder mapping the WB-stage event
//                sources to a single committed event.
//                Priority (highest first): INT, ADEF, INE, SYS, BRK, ALE, ERTN.
//                Any exception/interrupt alongside ERTN wins; ERTN is dropped.
//  Ports       : has_int   - enabled interrupt pending
//                ws_exc    - exception cause vector (ADEF,INE,SYS,BRK,ALE)
//                ws_ertn   - WB instruction is ERTN
//                take      - some event is present (validity gated outside)
//                is_ertn   - the selected event is an ERTN return
//                ecode     - selected exception code (0 for ERTN)
//                esubcode  - selected exception sub-code
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_enc
  import csr_exc_pkg::*;
#(
  parameter int NUM_EXC = 5
) (
  input  logic               has_int,
  input  logic [NUM_EXC-1:0] ws_exc,
  input  logic               ws_ertn,
  output logic               take,
  output logic               is_ertn,
  output logic [5:0]         ecode,
  output logic [8:0]         esubcode
);

  always_comb begin
    take     = has_int | (|ws_exc) | ws_ertn;
    is_ertn  = 1'b0;
    ecode    = c_ECODE_INT;
    esubcode = c_ESUB_NONE;

    if (has_int) begin
      ecode = c_ECODE_INT;
    end else if (ws_exc[c_EXC_ADEF]) begin
      ecode    = c_ECODE_ADEF;
      esubcode = c_ESUB_ADEF;
    end else if (ws_exc[c_EXC_INE]) begin
      ecode = c_ECODE_INE;
    end else if (ws_exc[c_EXC_SYS]) begin
      ecode = c_ECODE_SYS;
    end else if (ws_exc[c_EXC_BRK]) begin
      ecode = c_ECODE_BRK;
    end else if (ws_exc[c_EXC_ALE]) begin
      ecode = c_ECODE_ALE;
    end else if (ws_ertn) begin
      is_ertn = 1'b1;
    end
  end

endmodule : exc_prio_enc
`default_nettype wire

// File: rtl/csr_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csr_exc_ctrl
//  Description : Exception / interrupt / ERTN commit sequencer sitting between
//                the writeback stage, the CSR file and pre-IF.
//                IDLE     : evaluate WB, capture the winning event.
//                COMMIT   : one-cycle wb_ex / ertn_flush pulse, flush, latch
//                           the redirect target (ex_entry is stable here since
//                           it depends only on the registered wb_ecode).
//                REDIRECT : hold redirect_valid + flush_all until accepted.
//                All outputs are registered.
//  Ports       : clock, reset (synchronous, active-high)
//                ws_valid/ws_pc/ws_vaddr/ws_exc/ws_ertn - WB instruction info
//                has_int, ex_entry, era                 - from the CSR file
//                wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr/ertn_flush - to CSR
//                flush_all                               - pipeline kill
//                redirect_valid/redirect_pc/redirect_ready - pre-IF handshake
//                busy                                    - state != IDLE
//                exc_count (CSR_EXC_COUNT_EN only)       - wb_ex pulse count
//  Optional    : define CSR_EXC_COUNT_EN to add the exc_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_exc_ctrl
  import csr_exc_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int NUM_EXC = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ws_valid,
  input  logic [PC_W-1:0]    ws_pc,
  input  logic [PC_W-1:0]    ws_vaddr,
  input  logic [NUM_EXC-1:0] ws_exc,
  input  logic               ws_ertn,
  input  logic               has_int,
  input  logic [PC_W-1:0]    ex_entry,
  input  logic [PC_W-1:0]    era,
  output logic               wb_ex,
  output logic [5:0]         wb_ecode,
  output logic [8:0]         wb_esubcode,
  output logic [PC_W-1:0]    wb_pc,
  output logic [PC_W-1:0]    wb_vaddr,
  output logic               ertn_flush,
  output logic               flush_all,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  input  logic               redirect_ready,
  output logic               busy
`ifdef CSR_EXC_COUNT_EN
  ,
  output logic [31:0]        exc_count
`endif
);

  // --------------------------------------------------------------------------
  // Event selection
  // --------------------------------------------------------------------------
  logic       w_take;
  logic       w_is_ertn;
  logic [5:0] w_ecode;
  logic [8:0] w_esubcode;

  exc_prio_enc #(
    .NUM_EXC (NUM_EXC)
  ) u_prio_enc (
    .has_int  (has_int),
    .ws_exc   (ws_exc),
    .ws_ertn  (ws_ertn),
    .take     (w_take),
    .is_ertn  (w_is_ertn),
    .ecode    (w_ecode),
    .esubcode (w_esubcode)
  );

  // BADV takes the fetch PC for ADEF (the PC itself was the bad address),
  // the data address for everything else.
  logic [PC_W-1:0] w_cap_vaddr;
  assign w_cap_vaddr = (w_ecode == c_ECODE_ADEF && !w_is_ertn) ? ws_pc : ws_vaddr;

  logic w_start;
  assign w_start = ws_valid & w_take;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic            r_is_ertn;
  logic            r_wb_ex;
  logic            r_ertn_flush;
  logic            r_flush_all;
  logic            r_redirect_valid;
  logic            r_busy;
  logic [5:0]      r_wb_ecode;
  logic [8:0]      r_wb_esubcode;
  logic [PC_W-1:0] r_wb_pc;
  logic [PC_W-1:0] r_wb_vaddr;
  logic [PC_W-1:0] r_redirect_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= c_ST_IDLE;
      r_is_ertn        <= 1'b0;
      r_wb_ex          <= 1'b0;
      r_ertn_flush     <= 1'b0;
      r_flush_all      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_busy           <= 1'b0;
      r_wb_ecode       <= 6'd0;
      r_wb_esubcode    <= 9'd0;
      r_wb_pc          <= '0;
      r_wb_vaddr       <= '0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            r_is_ertn     <= w_is_ertn;
            r_wb_ecode    <= w_ecode;
            r_wb_esubcode <= w_esubcode;
            r_wb_pc       <= ws_pc;
            r_wb_vaddr    <= w_cap_vaddr;
            // The commit pulses are launched here so they appear during
            // COMMIT and are cleared again on leaving it.
            r_wb_ex       <= ~w_is_ertn;
            r_ertn_flush  <= w_is_ertn;
            r_flush_all   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= c_ST_COMMIT;
          end
        end

        c_ST_COMMIT: begin
          r_wb_ex          <= 1'b0;
          r_ertn_flush     <= 1'b0;
          r_redirect_pc    <= r_is_ertn ? era : ex_entry;
          r_redirect_valid <= 1'b1;
          r_state          <= c_ST_REDIRECT;
        end

        c_ST_REDIRECT: begin
          if (r_redirect_valid && redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_flush_all      <= 1'b0;
            r_busy           <= 1'b0;
            r_state          <= c_ST_IDLE;
          end
        end

        default: begin
          r_wb_ex          <= 1'b0;
          r_ertn_flush     <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_flush_all      <= 1'b0;
          r_busy           <= 1'b0;
          r_state          <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign wb_ex          = r_wb_ex;
  assign ertn_flush     = r_ertn_flush;
  assign flush_all      = r_flush_all;
  assign redirect_valid = r_redirect_valid;
  assign busy           = r_busy;
  assign wb_ecode       = r_wb_ecode;
  assign wb_esubcode    = r_wb_esubcode;
  assign wb_pc          = r_wb_pc;
  assign wb_vaddr       = r_wb_vaddr;
  assign redirect_pc    = r_redirect_pc;

`ifdef CSR_EXC_COUNT_EN
  // --------------------------------------------------------------------------
  // Exception counter: counts wb_ex pulses only, wraps naturally.
  // --------------------------------------------------------------------------
  logic [31:0] r_exc_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_exc_count <= 32'd0;
    end else if (r_wb_ex) begin
      r_exc_count <= r_exc_count + 32'd1;
    end
  end

  assign exc_count = r_exc_count;
`endif

endmodule : csr_exc_ctrl
`default_nettype wire

// File: doc/csr_exc_ctrl.md
Name: csr_exc_ctrl

Overview:
- Exception/interrupt/ERTN commit sequencer between the writeback stage, the CSR file and pre-IF.
- Each cycle, evaluates the instruction in WB against pending exception causes and the CSR interrupt flag.
- Selects the highest-priority event and drives the CSR file's exception-commit inputs for exactly one cycle.
- Flushes the pipeline, then holds a redirect request to pre-IF until it is accepted.

Parameters:
- PC_W, 32, width of PC, vaddr, entry and ERA buses.
- NUM_EXC, 5, width of ws_exc cause vector.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ws_valid  in  1  WB holds a valid instruction.
- ws_pc  in  PC_W  PC of the WB instruction.
- ws_vaddr  in  PC_W  memory address of the WB instruction.
- ws_exc  in  NUM_EXC  cause vector: bit0 ADEF, bit1 INE, bit2 SYS, bit3 BRK, bit4 ALE.
- ws_ertn  in  1  WB instruction is ERTN.
- has_int  in  1  enabled interrupt pending, from the CSR file.
- ex_entry  in  PC_W  exception entry, from the CSR file; combinational on wb_ecode.
- era  in  PC_W  current ERA value.
- wb_ex  out  1  exception commit pulse to the CSR file.
- wb_ecode  out  6  ecode to the CSR file.
- wb_esubcode  out  9  esubcode to the CSR file.
- wb_pc  out  PC_W  PC to record in ERA.
- wb_vaddr  out  PC_W  address to record in BADV.
- ertn_flush  out  1  ERTN commit pulse to the CSR file.
- flush_all  out  1  kill all stages and block new WB events.
- redirect_valid  out  1  redirect request to pre-IF.
- redirect_pc  out  PC_W  redirect target.
- redirect_ready  in  1  pre-IF accepts the redirect.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, COMMIT, REDIRECT. All outputs are registered.
- Reset: state=IDLE. wb_ex, ertn_flush, flush_all, redirect_valid and busy are 0. wb_ecode, wb_esubcode, wb_pc, wb_vaddr and redirect_pc are 0.
- An event is taken in IDLE when ws_valid && (|ws_exc || has_int || ws_ertn). ws_valid=0 never triggers, even with has_int=1.
- Priority, highest first:
  - INT: ecode 0x00.
  - ADEF: ecode 0x08, esub 0.
  - INE: ecode 0x0D.
  - SYS: ecode 0x0B.
  - BRK: ecode 0x0C.
  - ALE: ecode 0x09.
  - ERTN: no ecode.
- Non-ADEF esubcodes are 0.
- Any exception or interrupt together with ws_ertn is treated as an exception; ERTN is dropped.
- Capture at cycle T (IDLE):
  - Latch ecode, esubcode, wb_pc=ws_pc, an is_ertn flag, and wb_vaddr.
  - wb_vaddr = ws_pc for ADEF, ws_vaddr for ALE, otherwise ws_vaddr.
  - Next state is COMMIT.
- COMMIT (T+1):
  - wb_ex=1 (or ertn_flush=1 if is_ertn) for exactly this cycle. flush_all=1.
  - Latch redirect_pc = is_ertn ? era : ex_entry. ex_entry is valid because wb_ecode is stable.
  - Next state is REDIRECT.
- REDIRECT (T+2 onward):
  - redirect_valid=1 and flush_all=1. redirect_pc stays stable.
  - When redirect_valid && redirect_ready, go to IDLE next cycle; redirect_valid and flush_all drop.
  - Minimum event-to-IDLE time is 3 cycles.
- In COMMIT and REDIRECT, all ws_* inputs and has_int are ignored; nothing is queued.
- wb_ecode, wb_esubcode, wb_pc and wb_vaddr hold their last captured values until the next capture.
- A reset in any state returns to IDLE with the reset values on the next edge. No partial pulse occurs after reset.

Optional Feature:
- Macro: CSR_EXC_COUNT_EN.
- Defined: adds output exc_count[31:0]. It resets to 0 and increments by 1 on each wb_ex pulse (not on ertn_flush). It wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package csr_exc_pkg holds:
  - the ecode/esubcode constants;
  - the ws_exc bit indices;
  - the state encoding (IDLE=0, COMMIT=1, REDIRECT=2).
- Sub-module exc_prio_enc: combinational mapping of (has_int, ws_exc, ws_ertn) to (take, is_ertn, ecode, esubcode).

Test Plan:
1. SYS at pc=0x1C000100, ex_entry=0x1C008000, redirect_ready=1:
   - wb_ex at T+1 with ecode 0x0B and wb_pc=0x1C000100.
   - redirect_pc=0x1C008000 with redirect_valid at T+2; IDLE at T+3.
2. ALE (vaddr=0x00000003) together with has_int=1 → ecode 0x00, single wb_ex pulse.
3. ADEF at pc=0x1C000002 → ecode 0x08, esub 0, wb_vaddr=0x1C000002.
4. ERTN with era=0x1C000200:
   - ertn_flush=1 for 1 cycle, wb_ex=0, redirect_pc=0x1C000200.
   - ERTN+BRK instead gives ecode 0x0C with ertn_flush=0.
5. redirect_ready=0 for 5 cycles, with a new SYS presented meanwhile:
   - redirect_valid and flush_all stay high and redirect_pc stays stable.
   - The second event is ignored; exactly one wb_ex pulse occurs.
6. Reset asserted during REDIRECT → next cycle all outputs 0 and busy=0. With CSR_EXC_COUNT_EN, three exceptions give exc_count=3.
